// File: rtl/tube_pkg.sv
// Shared types and constants for the 4-digit tube scan scheduler.
package tube_pkg;

  typedef enum logic [0:0] {
    BLANK_ST = 1'b0,
    ON_ST    = 1'b1
  } state_t;

  localparam int DIGITS = 4;
  localparam logic [1:0] LAST_DIG = 2'(DIGITS - 1);

  // Nibble positions of each digit inside wrData
  localparam int DIG1_LSB = 0;
  localparam int DIG2_LSB = 4;
  localparam int DIG3_LSB = 8;
  localparam int DIG4_LSB = 12;

endpackage

// File: rtl/tube_scan_scheduler_if.sv
// CPU write bus into the tube scan scheduler.
interface tube_scan_scheduler_if;
  logic        wrEn;
  logic [15:0] wrData;
  logic [3:0]  wrDots;

  modport master (output wrEn, wrData, wrDots);
  modport slave  (input  wrEn, wrData, wrDots);
endinterface

// File: rtl/tube_pwm.sv
// Brightness PWM: free-running 4-bit phase counter compared against the duty.
module tube_pwm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] brightness,
  output logic       pwm_on
);

  logic [3:0] pwm_cnt_r;

  // Free-running PWM phase counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_r <= 4'd0;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + 4'd1;
    end
  end

  // Full scale is forced on so that duty 15 means no PWM gaps at all
  assign pwm_on = (brightness == 4'd15) || (pwm_cnt_r < brightness);

endmodule

// File: rtl/tube_scan_scheduler.sv
// Digit scan sequencer with ghosting blank, brightness PWM and a tear-free
// double-buffered digit/dot register set.
module tube_scan_scheduler
  import tube_pkg::*;
#(
  parameter int PRESCALE = 1000,
  parameter int BLANK    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tube_scan_scheduler_if.slave  wr,
  input  logic [3:0]            brightness,
  output logic [1:0]            dig,
  output logic [3:0]            dig1,
  output logic [3:0]            dig2,
  output logic [3:0]            dig3,
  output logic [3:0]            dig4,
  output logic [3:0]            dots,
  output logic                  dispEn,
  output logic                  frameTick,
  output logic                  pending
);

  localparam int CW = $clog2(PRESCALE);

  logic [CW-1:0] slot_cnt_r;
  logic [1:0]    dig_r;
  state_t        state_r;
  state_t        state_next_s;
  logic          disp_en_r;
  logic          disp_en_next_s;
  logic          frame_tick_r;
  logic          pending_r;
  logic [15:0]   shadow_data_r;
  logic [3:0]    shadow_dots_r;
  logic [15:0]   act_data_r;
  logic [3:0]    act_dots_r;
  logic          pwm_on_s;
  logic          tc_s;
  logic          blank_end_s;
  logic          boundary_s;

  assign tc_s        = (slot_cnt_r == CW'(PRESCALE - 1));
  assign blank_end_s = (slot_cnt_r == CW'(BLANK - 1));
  assign boundary_s  = tc_s && (dig_r == LAST_DIG);

  tube_pwm u_pwm (
    .clk        (clk),
    .rst_n      (rst_n),
    .brightness (brightness),
    .pwm_on     (pwm_on_s)
  );

  // Slot counter, digit index and frame tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_r   <= '0;
      dig_r        <= 2'd0;
      frame_tick_r <= 1'b0;
    end else begin
      frame_tick_r <= boundary_s;
      if (tc_s) begin
        slot_cnt_r <= '0;
        dig_r      <= dig_r + 2'd1;
      end else begin
        slot_cnt_r <= slot_cnt_r + CW'(1);
      end
    end
  end

  // FSM state and registered display enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= BLANK_ST;
      disp_en_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      disp_en_r <= disp_en_next_s;
    end
  end

  // Next state; dispEn is computed from the next state so it lines up with it
  always_comb begin
    state_next_s   = state_r;
    disp_en_next_s = 1'b0;
    case (state_r)
      BLANK_ST: begin
        if (blank_end_s) state_next_s = ON_ST;
        else             state_next_s = BLANK_ST;
      end
      ON_ST: begin
        if (tc_s) state_next_s = BLANK_ST;
        else      state_next_s = ON_ST;
      end
      default: state_next_s = BLANK_ST;
    endcase
    if (state_next_s == ON_ST) disp_en_next_s = pwm_on_s;
    else                       disp_en_next_s = 1'b0;
  end

  // Shadow/active double buffer; a write on the boundary bypasses the shadow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_data_r <= 16'h0000;
      shadow_dots_r <= 4'h0;
      act_data_r    <= 16'h0000;
      act_dots_r    <= 4'h0;
      pending_r     <= 1'b0;
    end else begin
      if (wr.wrEn) begin
        shadow_data_r <= wr.wrData;
        shadow_dots_r <= wr.wrDots;
      end
      if (boundary_s) begin
        pending_r <= 1'b0;
        if (wr.wrEn) begin
          act_data_r <= wr.wrData;
          act_dots_r <= wr.wrDots;
        end else if (pending_r) begin
          act_data_r <= shadow_data_r;
          act_dots_r <= shadow_dots_r;
        end
      end else if (wr.wrEn) begin
        pending_r <= 1'b1;
      end
    end
  end

  assign dig       = dig_r;
  assign dig1      = act_data_r[DIG1_LSB +: 4];
  assign dig2      = act_data_r[DIG2_LSB +: 4];
  assign dig3      = act_data_r[DIG3_LSB +: 4];
  assign dig4      = act_data_r[DIG4_LSB +: 4];
  assign dots      = act_dots_r;
  assign dispEn    = disp_en_r;
  assign frameTick = frame_tick_r;
  assign pending   = pending_r;

endmodule
